// File: rtl/decred_result_collector.sv
// decred_result_collector
//
// Initiator-side reader for the hash-macro result interface (m1_clk_local domain).
// Scans the per-macro DATA_AVAILABLE flags round-robin, requests the shared macro read
// bus, reads the pending 32-bit nonce byte by byte (little-endian, RESULT_BASE..+3) and
// queues {macro id, nonce} in a show-ahead FIFO drained by the SPI register file.
//
// Optional feature: define DECRED_RESULT_DEDUP_EN to drop an entry identical to the last
// pushed one and count it on dup_count_o (saturating at 255). Undefined: every collected
// entry is pushed and dup_count_o does not exist.
//
// Ports:
//   clk_i              collector clock
//   rst_ni             asynchronous active-low reset
//   scan_en_i          enable collection; low finishes the current entry then idles
//   data_available_i   per-macro result-pending flags
//   bus_req_o          request for the shared read bus
//   bus_gnt_i          read bus granted
//   macro_rd_select_o  one-hot read select, zero when not granted
//   hash_addr_o        read address, zero unless a select bit is high
//   data_from_hash_i   read data from the selected macro
//   result_valid_o     FIFO non-empty
//   result_ready_i     pop strobe
//   result_nonce_o     FIFO head nonce
//   result_macro_o     FIFO head macro id
//   fifo_count_o       FIFO occupancy
//   result_irq_o       result_valid_o delayed by one cycle
//   dup_count_o        duplicate entries dropped (DECRED_RESULT_DEDUP_EN only)

module decred_result_collector #(
  parameter int unsigned          NUM_MACROS  = 4,
  parameter int unsigned          ID_W        = 2,
  parameter int unsigned          ADDR_W      = 6,
  parameter logic [ADDR_W-1:0]    RESULT_BASE = 6'h3C,
  parameter int unsigned          RD_LATENCY  = 1,
  parameter int unsigned          FIFO_DEPTH  = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            scan_en_i,
  input  logic [NUM_MACROS-1:0]           data_available_i,
  output logic                            bus_req_o,
  input  logic                            bus_gnt_i,
  output logic [NUM_MACROS-1:0]           macro_rd_select_o,
  output logic [ADDR_W-1:0]               hash_addr_o,
  input  logic [7:0]                      data_from_hash_i,
  output logic                            result_valid_o,
  input  logic                            result_ready_i,
  output logic [31:0]                     result_nonce_o,
  output logic [ID_W-1:0]                 result_macro_o,
`ifdef DECRED_RESULT_DEDUP_EN
  output logic [7:0]                      dup_count_o,
`endif
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
  output logic                            result_irq_o
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntW   = ID_W + 32;
  localparam logic [1:0]  LatMax = 2'(RD_LATENCY);

  typedef enum logic [2:0] {StIdle, StReq, StAddr, StWait, StPush} state_e;

  state_e                state_q;
  logic [ID_W-1:0]       win_q;
  logic [ID_W-1:0]       rr_q;
  logic [1:0]            byte_idx_q;
  logic [1:0]            lat_cnt_q;
  logic [31:0]           nonce_q;
  logic                  bus_req_q;
  logic [NUM_MACROS-1:0] sel_q;
  logic [ADDR_W-1:0]     addr_q;

  logic [EntW-1:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  irq_q;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic                  is_dup;
  logic                  scan_start;
  logic [ID_W-1:0]       rr_pick;
  logic [ID_W-1:0]       rr_next;
  logic [ID_W-1:0]       cand;
  logic                  found;
  logic [NUM_MACROS-1:0] win_sel;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign scan_start = scan_en_i && (|data_available_i) && !fifo_full;
  assign rr_next    = (win_q == ID_W'(NUM_MACROS - 1)) ? '0 : win_q + 1'b1;

  // First pending macro at or after rr_q (rr_q holds last served + 1).
  always_comb begin
    rr_pick = rr_q;
    cand    = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_MACROS; i++) begin
      cand = ID_W'((32'(rr_q) + i) % NUM_MACROS);
      if (!found && data_available_i[cand]) begin
        rr_pick = cand;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    win_sel        = '0;
    win_sel[win_q] = 1'b1;
  end

  // Collection FSM. Any loss of grant in ADDR/WAIT restarts the macro from byte 0.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      win_q      <= '0;
      rr_q       <= '0;
      byte_idx_q <= '0;
      lat_cnt_q  <= '0;
      nonce_q    <= '0;
      bus_req_q  <= 1'b0;
      sel_q      <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (scan_start) begin
            win_q      <= rr_pick;
            byte_idx_q <= '0;
            bus_req_q  <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          if (bus_gnt_i) begin
            sel_q   <= win_sel;
            addr_q  <= RESULT_BASE + ADDR_W'(byte_idx_q);
            state_q <= StAddr;
          end
        end
        StAddr: begin
          sel_q <= '0;
          if (!bus_gnt_i) begin
            byte_idx_q <= '0;
            nonce_q    <= '0;
            state_q    <= StReq;
          end else begin
            lat_cnt_q <= 2'd1;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (!bus_gnt_i) begin
            byte_idx_q <= '0;
            nonce_q    <= '0;
            state_q    <= StReq;
          end else if (lat_cnt_q == LatMax) begin
            nonce_q[8*byte_idx_q +: 8] <= data_from_hash_i;
            if (byte_idx_q == 2'd3) begin
              bus_req_q <= 1'b0;
              state_q   <= StPush;
            end else begin
              byte_idx_q <= byte_idx_q + 2'd1;
              sel_q      <= win_sel;
              addr_q     <= RESULT_BASE + ADDR_W'(byte_idx_q + 2'd1);
              state_q    <= StAddr;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        StPush: begin
          rr_q    <= rr_next;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef DECRED_RESULT_DEDUP_EN
  logic            last_vld_q;
  logic [EntW-1:0] last_q;
  logic [7:0]      dup_q;

  assign is_dup      = last_vld_q && (last_q == {win_q, nonce_q});
  assign dup_count_o = dup_q;

  // Last pushed entry survives pops; only reset forgets it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_vld_q <= 1'b0;
      last_q     <= '0;
      dup_q      <= '0;
    end else if (state_q == StPush) begin
      if (is_dup) begin
        if (dup_q != 8'hFF) begin
          dup_q <= dup_q + 8'd1;
        end
      end else begin
        last_vld_q <= 1'b1;
        last_q     <= {win_q, nonce_q};
      end
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  assign push = (state_q == StPush) && !is_dup;
  assign pop  = result_ready_i && !fifo_empty;

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {win_q, nonce_q};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CntW'(1);
      end
      irq_q <= !fifo_empty;
    end
  end

  assign bus_req_o         = bus_req_q;
  assign macro_rd_select_o = bus_gnt_i ? sel_q : '0;
  assign hash_addr_o       = (|macro_rd_select_o) ? addr_q : '0;
  assign result_valid_o    = !fifo_empty;
  assign result_nonce_o    = fifo_empty ? '0 : mem_q[rd_ptr_q][31:0];
  assign result_macro_o    = fifo_empty ? '0 : mem_q[rd_ptr_q][EntW-1:32];
  assign fifo_count_o      = count_q;
  assign result_irq_o      = irq_q;

endmodule

// File: tb/tb_decred_result_collector.sv
// Self-checking bench for decred_result_collector: behavioural macro responders plus a
// scoreboard of expected {macro, nonce} entries compared as the FIFO is drained.

module tb_decred_result_collector;

`ifdef DECRED_RESULT_DEDUP_EN
  localparam bit DedupEn = 1'b1;
`else
  localparam bit DedupEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        scan_en;
  logic [3:0]  da;
  logic        bus_req;
  logic        bus_gnt;
  logic [3:0]  sel;
  logic [5:0]  hash_addr;
  logic [7:0]  data_from_hash;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] result_nonce;
  logic [1:0]  result_macro;
  logic [3:0]  fifo_count;
  logic        result_irq;
`ifdef DECRED_RESULT_DEDUP_EN
  logic [7:0]  dup_count;
`endif

  decred_result_collector dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .scan_en_i         (scan_en),
    .data_available_i  (da),
    .bus_req_o         (bus_req),
    .bus_gnt_i         (bus_gnt),
    .macro_rd_select_o (sel),
    .hash_addr_o       (hash_addr),
    .data_from_hash_i  (data_from_hash),
    .result_valid_o    (result_valid),
    .result_ready_i    (result_ready),
    .result_nonce_o    (result_nonce),
    .result_macro_o    (result_macro),
`ifdef DECRED_RESULT_DEDUP_EN
    .dup_count_o       (dup_count),
`endif
    .fifo_count_o      (fifo_count),
    .result_irq_o      (result_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: a flag is pending while raises outnumber completed reads; a read of
  // 0x3F clears it. Data appears one cycle after the select/address.
  logic [31:0] nonce_tab [4];
  int          pend_gen [4];
  int          read_gen [4];
  logic [5:0]  addr_log [$];
  logic [33:0] sb [$];
  int          n_checks;
  int          n_errors;

  function automatic logic [7:0] pick_byte(input logic [31:0] n, input logic [5:0] a);
    case (a)
      6'h3C:   return n[7:0];
      6'h3D:   return n[15:8];
      6'h3E:   return n[23:16];
      6'h3F:   return n[31:24];
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    da = '0;
    for (int i = 0; i < 4; i++) da[i] = (pend_gen[i] != read_gen[i]);
  end

  initial data_from_hash = 8'h00;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        data_from_hash <= pick_byte(nonce_tab[i], hash_addr);
        addr_log.push_back(hash_addr);
        if (hash_addr == 6'h3F) read_gen[i] <= read_gen[i] + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic raise(input int id, input logic [31:0] n, input bit expect_it);
    nonce_tab[id] = n;
    pend_gen[id]  = pend_gen[id] + 1;
    if (expect_it) sb.push_back({2'(id), n});
  endtask

  task automatic wait_count(input int n, input string tag);
    int k = 0;
    while (32'(fifo_count) != n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 64'(fifo_count), 64'(n));
  endtask

  task automatic wait_read(input int id, input string tag);
    int k = 0;
    while (pend_gen[id] != read_gen[id] && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, 64'(da[id]), 64'd0);
  endtask

  task automatic wait_sel_addr(input logic [5:0] a, input string tag);
    int k = 0;
    while (!((|sel) && hash_addr == a) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, {57'd0, |sel, hash_addr}, {57'd0, 1'b1, a});
  endtask

  task automatic pop_check(input string tag);
    logic [33:0] exp;
    int k = 0;
    while (!result_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    exp = (sb.size() > 0) ? sb.pop_front() : 34'h3_FFFF_FFFF;
    check_eq({tag, "_valid"}, 64'(result_valid), 64'd1);
    check_eq({tag, "_macro"}, 64'(result_macro), 64'(exp[33:32]));
    check_eq({tag, "_nonce"}, 64'(result_nonce), 64'(exp[31:0]));
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic check_reads(input int base, input string tag);
    check_eq({tag, "_nreads"}, 64'(addr_log.size() - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (addr_log.size() > base + i) check_eq({tag, "_addr"}, 64'(addr_log[base+i]), 64'(60 + i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lat;
    int cnt;
    logic [3:0] sel_seen;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 4; i++) begin
      pend_gen[i]  = 0;
      read_gen[i]  = 0;
      nonce_tab[i] = '0;
    end
    rst_n = 1'b0;
    scan_en = 1'b1;
    bus_gnt = 1'b1;
    result_ready = 1'b0;
    tick(2);
    check_eq("rst_bus_req", 64'(bus_req), 64'd0);
    check_eq("rst_valid", 64'(result_valid), 64'd0);
    check_eq("rst_count", 64'(fifo_count), 64'd0);
    check_eq("rst_sel", 64'(sel), 64'd0);
    check_eq("rst_irq", 64'(result_irq), 64'd0);
    check_eq("rst_nonce", 64'(result_nonce), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Single result from macro 2, immediate grant.
    base = addr_log.size();
    raise(2, 32'hDEADBEEF, 1'b1);
    lat = 0;
    while (!result_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t1_latency", 64'(lat), 64'd11);
    check_eq("t1_irq_lag", 64'(result_irq), 64'd0);
    check_eq("t1_count", 64'(fifo_count), 64'd1);
    check_reads(base, "t1");
    tick(1);
    check_eq("t1_irq", 64'(result_irq), 64'd1);
    pop_check("t1");
    check_eq("t1_empty", 64'(result_valid), 64'd0);
    tick(1);
    check_eq("t1_irq_clear", 64'(result_irq), 64'd0);

    // Round-robin: macro 0 served, then 0 and 3 pending together -> 3 first.
    raise(0, 32'h00C0FFEE, 1'b1);
    pop_check("t2a");
    raise(3, 32'h33333333, 1'b1);
    raise(0, 32'h0000AAAA, 1'b1);
    wait_count(2, "t2_count");
    pop_check("t2b");
    pop_check("t2c");

    // Backpressure: fill the FIFO, macro 1 must wait until a slot frees.
    for (int k = 0; k < 8; k++) begin
      raise((k % 2 == 0) ? 2 : 3, 32'hB000_0000 + 32'(k), 1'b1);
      wait_count(k + 1, "t3_fill");
    end
    raise(1, 32'h11111111, 1'b1);
    cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus_req) cnt++;
    end
    check_eq("t3_req_blocked", 64'(cnt), 64'd0);
    check_eq("t3_full_count", 64'(fifo_count), 64'd8);
    check_eq("t3_still_pending", 64'(da[1]), 64'd1);
    pop_check("t3_pop0");
    wait_count(8, "t3_refill");
    check_eq("t3_collected", 64'(da[1]), 64'd0);
    for (int k = 0; k < 8; k++) pop_check("t3_drain");

    // Grant delay, then revoke during byte 1.
    bus_gnt = 1'b0;
    raise(1, 32'hA5A55A5A, 1'b1);
    sel_seen = '0;
    repeat (5) begin
      @(negedge clk);
      sel_seen |= sel;
    end
    check_eq("t4_no_sel", 64'(sel_seen), 64'd0);
    check_eq("t4_req", 64'(bus_req), 64'd1);
    bus_gnt = 1'b1;
    wait_sel_addr(6'h3D, "t4_byte1");
    bus_gnt = 1'b0;
    #1;
    check_eq("t4_revoke_sel", 64'(sel), 64'd0);
    base = addr_log.size();
    @(negedge clk);
    check_eq("t4_req_held", 64'(bus_req), 64'd1);
    bus_gnt = 1'b1;
    pop_check("t4");
    check_reads(base, "t4");

    // Asynchronous reset in the WAIT of byte 2 with one entry queued.
    raise(0, 32'h11112222, 1'b1);
    wait_count(1, "t5_pre");
    raise(2, 32'h0BADF00D, 1'b0);
    wait_sel_addr(6'h3E, "t5_byte2");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("t5_bus_req", 64'(bus_req), 64'd0);
    check_eq("t5_sel", 64'(sel), 64'd0);
    check_eq("t5_valid", 64'(result_valid), 64'd0);
    check_eq("t5_count", 64'(fifo_count), 64'd0);
    check_eq("t5_irq", 64'(result_irq), 64'd0);
    check_eq("t5_nonce", 64'(result_nonce), 64'd0);
    sb.delete();
    sb.push_back({2'd2, 32'h0BADF00D});
    base = addr_log.size();
    tick(2);
    rst_n = 1'b1;
    pop_check("t5_after");
    check_reads(base, "t5");

    // scan_en dropped mid-entry: entry completes, nothing new starts.
    raise(3, 32'h3C3C3C3C, 1'b1);
    lat = 0;
    while (!bus_req && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("t6_req", 64'(bus_req), 64'd1);
    scan_en = 1'b0;
    wait_count(1, "t6_finish");
    raise(0, 32'h0F0F0F0F, 1'b1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_req) cnt++;
    end
    check_eq("t6_idle", 64'(cnt), 64'd0);
    check_eq("t6_pending", 64'(da[0]), 64'd1);
    pop_check("t6a");
    scan_en = 1'b1;
    pop_check("t6b");

    // Same result twice from macro 1.
    raise(1, 32'h12345678, 1'b1);
    wait_read(1, "t7_read1");
    tick(5);
    raise(1, 32'h12345678, !DedupEn);
    wait_read(1, "t7_read2");
    tick(5);
    check_eq("t7_count", 64'(fifo_count), DedupEn ? 64'd1 : 64'd2);
`ifdef DECRED_RESULT_DEDUP_EN
    check_eq("t7_dup_count", 64'(dup_count), 64'd1);
`endif
    pop_check("t7a");
    if (!DedupEn) pop_check("t7b");
    tick(2);
    check_eq("t7_empty", 64'(result_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decred_result_collector.md
Name: decred_result_collector

Overview:
- Initiator-side reader for the hash-macro result interface; sits beside decred_controller on the m1_clk_local domain.
- Watches the per-macro DATA_AVAILABLE flags and arbitrates for the shared macro read bus.
- Reads each pending 32-bit nonce byte-wise over MACRO_RD_SELECT/HASH_ADDR/DATA_FROM_HASH and queues {macro id, nonce} in a FIFO that the SPI register file drains.

Parameters:
NUM_MACROS, 4, number of hash macros scanned
ID_W, 2, width of macro id (clog2 NUM_MACROS)
ADDR_W, 6, HASH_ADDR width
RESULT_BASE, 6'h3C, address of nonce byte 0 in each macro
RD_LATENCY, 1, cycles from address/select to valid DATA_FROM_HASH (1..3)
FIFO_DEPTH, 8, result FIFO entries (power of 2)

Ports:
CLK  in  1  collector clock (m1_clk_local)
RESET_N  in  1  asynchronous active-low reset
SCAN_EN  in  1  enable collection; low = finish current entry then idle
DATA_AVAILABLE  in  NUM_MACROS  per-macro result-pending flags
BUS_REQ  out  1  request for the shared HASH_ADDR/read bus
BUS_GNT  in  1  bus granted by controller
MACRO_RD_SELECT  out  NUM_MACROS  one-hot read select, zero when not granted
HASH_ADDR  out  ADDR_W  read address, valid only while a select bit is high
DATA_FROM_HASH  in  8  read data from the selected macro
RESULT_VALID  out  1  FIFO non-empty
RESULT_READY  in  1  pop strobe from the consumer
RESULT_NONCE  out  32  FIFO head nonce
RESULT_MACRO  out  ID_W  FIFO head macro id
FIFO_COUNT  out  clog2(FIFO_DEPTH)+1  occupancy
RESULT_IRQ  out  1  level: RESULT_VALID registered

Behaviour:
- Reset (asynchronous): all outputs 0; FSM in IDLE; FIFO empty; round-robin pointer 0. Applies immediately, including mid-read.
- FSM states:
  - IDLE: move to REQ when SCAN_EN=1, any DATA_AVAILABLE=1, and FIFO_COUNT<FIFO_DEPTH. Winner is chosen round-robin starting at (last served + 1) mod NUM_MACROS and latched.
  - REQ: BUS_REQ=1. Move to ADDR the cycle after BUS_GNT is seen high.
  - ADDR: MACRO_RD_SELECT[win]=1 and HASH_ADDR=RESULT_BASE+byte_idx for exactly 1 cycle, then WAIT.
  - WAIT: count RD_LATENCY cycles, then capture DATA_FROM_HASH into nonce[8*byte_idx +: 8] (little-endian).
  - After capture: if byte_idx<3, increment it and return to ADDR; otherwise go to PUSH.
  - PUSH: write {win, nonce} into the FIFO; drop BUS_REQ; update the RR pointer; go to IDLE.
- Latency per entry: 4*(1+RD_LATENCY)+1 cycles after grant. Minimum IDLE-to-IDLE is 11 cycles with RD_LATENCY=1 and immediate grant.
- BUS_REQ stays high from REQ through the last capture and is low in IDLE and PUSH.
- The macro clears its DATA_AVAILABLE on the read of RESULT_BASE+3. The collector does not sample DATA_AVAILABLE again until back in IDLE.
- BUS_GNT low while in ADDR or WAIT:
  - Abort: selects go to 0 the same cycle; return to REQ.
  - Restart at byte 0 of the same macro. Partial bytes are discarded.
  - If the abort hits after byte 3's address was issued, the result is lost (the macro has already cleared). The controller must not revoke a grant while BUS_REQ=1.
- FIFO:
  - Show-ahead: RESULT_NONCE/RESULT_MACRO are valid whenever RESULT_VALID=1.
  - A pop happens when RESULT_READY && RESULT_VALID. RESULT_READY while empty is ignored.
  - A simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
  - Full: no new scan starts; results wait in the macros. There is no overflow path.
- SCAN_EN falling mid-entry: the current entry completes and is pushed, then the FSM stays in IDLE.
- RESULT_IRQ = registered RESULT_VALID (1-cycle lag).

Optional Feature:
- Macro DECRED_RESULT_DEDUP_EN.
- When defined: PUSH compares {win, nonce} with the last pushed entry (held across pops, cleared at reset). On a match the entry is discarded, the FIFO is unchanged, and an extra output DUP_COUNT[7:0] increments, saturating at 255.
- When undefined: every collected entry is pushed, and the DUP_COUNT port does not exist.

Test Plan:
- Single result: macro 2 raises DATA_AVAILABLE with nonce bytes 3C..3F = EF,BE,AD,DE; grant immediate → reads at 3C,3D,3E,3F; RESULT_NONCE=32'hDEADBEEF, RESULT_MACRO=2, RESULT_VALID 11 cycles after request.
- Round-robin: macros 0 and 3 both pending after macro 0 was last served → 3 collected first, then 0; FIFO_COUNT=2; pops return 3 then 0.
- Backpressure: fill 8 entries with RESULT_READY=0 while macro 1 stays pending → BUS_REQ stays 0; one pop → collection of macro 1 resumes, FIFO_COUNT returns to 8.
- Grant delay and revoke: BUS_GNT held low 5 cycles → MACRO_RD_SELECT stays 0; revoke during byte 1 → selects 0 immediately, re-read starts at address 3C.
- Async reset asserted in WAIT of byte 2 → all outputs 0 the same cycle, FIFO empty; after release with macro still pending, a full 4-byte read occurs.
- DEDUP_EN: macro 1 delivers 32'h12345678 twice → one FIFO entry, DUP_COUNT=1. Without the macro → two entries.
